associative_fill_controller: RTL
================================

Name: associative_fill_controller

Overview:
- Request-side controller sitting directly upstream of the associative_block cache set.
- Accepts single read requests from the core and presents the address to the set.
- On a hit, returns the set's data. On a miss, fetches the word from backing memory, writes it into the set via a one-cycle set pulse, then returns it.
- Keeps saturating hit/miss statistics counters.

Parameters:
BITS_DATA, 32, width of a data word
BITS_ADDRESS, 32, width of an address
BITS_COUNT, 16, width of each statistics counter

Ports:
clock  input  1  single clock; all logic on posedge
reset  input  1  synchronous, active-high reset
cpu_req_valid  input  1  core request present
cpu_req_ready  output  1  controller can accept a request (high only in IDLE)
cpu_address  input  BITS_ADDRESS  request address, sampled on the req handshake
cpu_resp_valid  output  1  one-cycle response strobe
cpu_resp_data  output  BITS_DATA  response word; holds until the next response
blk_address  output  BITS_ADDRESS  address presented to the cache set
blk_hit  input  1  set hit indication, valid in LOOKUP
blk_data  input  BITS_DATA  set read data, valid in LOOKUP
blk_set  output  1  one-cycle fill strobe to the cache set
blk_fill_data  output  BITS_DATA  word to be written on blk_set
mem_req_valid  output  1  memory read request
mem_req_ready  input  1  memory accepts the request
mem_address  output  BITS_ADDRESS  memory read address
mem_resp_valid  input  1  memory read data valid
mem_resp_data  input  BITS_DATA  memory read data
hit_count  output  BITS_COUNT  saturating hit counter
miss_count  output  BITS_COUNT  saturating miss counter

Behaviour:
- Reset values:
  - State is IDLE.
  - All registers and outputs are 0: cpu_resp_data, blk_address, blk_fill_data, mem_address, counters.
  - cpu_req_ready is 1 once in IDLE.
- FSM states: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, RESPOND.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid: latch cpu_address into the address register, then go to LOOKUP.
- Address outputs: blk_address and mem_address are both driven from the address register.
- LOOKUP (exactly 1 cycle): sample blk_hit.
  - Hit: cpu_resp_data<=blk_data, hit_count++, go to RESPOND.
  - Miss: miss_count++, go to MEM_REQ.
- MEM_REQ:
  - mem_req_valid=1, held until mem_req_ready.
  - Handshake cycle goes to MEM_WAIT.
  - Address must remain stable while waiting.
- MEM_WAIT:
  - On mem_resp_valid: blk_fill_data<=mem_resp_data and cpu_resp_data<=mem_resp_data, go to FILL.
  - Unbounded wait; no timeout.
- FILL: blk_set=1 for exactly one cycle, go to RESPOND.
- RESPOND: cpu_resp_valid=1 for exactly one cycle (core has no backpressure), go to IDLE.
- Latency, with the request accepted at cycle 0:
  - Hit: cpu_resp_valid in cycle 2.
  - Miss: mem_req_valid from cycle 2. If mem_resp_valid arrives in cycle t, blk_set is in t+1 and cpu_resp_valid in t+2.
- Back-to-back requests: a new request can be accepted in the cycle after RESPOND (IDLE). Minimum hit-to-hit spacing is 3 cycles.
- mem_resp_valid outside MEM_WAIT is ignored, including in the MEM_REQ handshake cycle. Memory must respond no earlier than the cycle after acceptance.
- blk_hit/blk_data are ignored outside LOOKUP.
- Counters:
  - Saturate at 2^BITS_COUNT-1; no wrap.
  - Incremented only in LOOKUP, at most one increment per request.
- Reset mid-operation (any state):
  - Next cycle is IDLE with all registers cleared.
  - Any outstanding memory response is dropped (ignored, since it arrives outside MEM_WAIT).
  - No blk_set or cpu_resp_valid is emitted.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Test Plan:
- Reset, then idle -> cpu_req_ready=1, all other outputs 0, hit_count=miss_count=0.
- Request addr 0x100, blk_hit=1, blk_data=0xDEADBEEF in LOOKUP -> cpu_resp_valid in cycle 2, cpu_resp_data=0xDEADBEEF, hit_count=1, mem_req_valid never asserted.
- Request addr 0x200 miss; mem_req_ready low 3 cycles, then high; mem_resp 0x12345678 two cycles later:
  - mem_address=0x200 stable throughout the wait.
  - blk_set=1 for one cycle with blk_fill_data=0x12345678.
  - cpu_resp_valid the next cycle with data 0x12345678.
  - miss_count=1.
- Spurious mem_resp_valid in IDLE and in the MEM_REQ handshake cycle -> ignored; the FSM still waits for the real response in MEM_WAIT.
- Reset asserted during MEM_WAIT, then mem_resp_valid -> returns to IDLE, no blk_set, no cpu_resp_valid, counters 0.
- BITS_COUNT=2, five consecutive hits -> hit_count saturates at 3.

Source files
------------

// File: rtl/associative_fill_controller_if.sv
// Bundles the core, cache-set and memory signals of associative_fill_controller.
// The master side is the surrounding system; the slave side is the controller.
interface associative_fill_controller_if #(
  parameter int BITS_DATA    = 32,
  parameter int BITS_ADDRESS = 32,
  parameter int BITS_COUNT   = 16
);
  logic                    cpu_req_valid;
  logic                    cpu_req_ready;
  logic [BITS_ADDRESS-1:0] cpu_address;
  logic                    cpu_resp_valid;
  logic [BITS_DATA-1:0]    cpu_resp_data;
  logic [BITS_ADDRESS-1:0] blk_address;
  logic                    blk_hit;
  logic [BITS_DATA-1:0]    blk_data;
  logic                    blk_set;
  logic [BITS_DATA-1:0]    blk_fill_data;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [BITS_ADDRESS-1:0] mem_address;
  logic                    mem_resp_valid;
  logic [BITS_DATA-1:0]    mem_resp_data;
  logic [BITS_COUNT-1:0]   hit_count;
  logic [BITS_COUNT-1:0]   miss_count;

  modport master (
    output cpu_req_valid, cpu_address, blk_hit, blk_data,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, blk_address,
           blk_set, blk_fill_data, mem_req_valid, mem_address,
           hit_count, miss_count
  );

  modport slave (
    input  cpu_req_valid, cpu_address, blk_hit, blk_data,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data, blk_address,
           blk_set, blk_fill_data, mem_req_valid, mem_address,
           hit_count, miss_count
  );
endinterface

// File: rtl/associative_fill_controller.sv
// Read-request controller in front of an associative cache set: looks up,
// fills from memory on a miss, responds, and keeps saturating hit/miss counts.
module associative_fill_controller #(
  parameter int BITS_DATA    = 32,
  parameter int BITS_ADDRESS = 32,
  parameter int BITS_COUNT   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  associative_fill_controller_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_WAIT, S_FILL, S_RESPOND
  } state_e;

  state_e                  state_q, state_d;
  logic [BITS_ADDRESS-1:0] addr_q, addr_d;
  logic [BITS_DATA-1:0]    resp_data_q, resp_data_d;
  logic [BITS_DATA-1:0]    fill_data_q, fill_data_d;
  logic [BITS_COUNT-1:0]   hit_q, hit_d;
  logic [BITS_COUNT-1:0]   miss_q, miss_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      resp_data_q <= '0;
      fill_data_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      resp_data_q <= resp_data_d;
      fill_data_q <= fill_data_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    resp_data_d = resp_data_q;
    fill_data_d = fill_data_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_req_valid) begin
          addr_d  = bus.cpu_address;
          state_d = S_LOOKUP;
        end
      end
      // Counters only move here, so each request bumps exactly one of them once.
      S_LOOKUP: begin
        if (bus.blk_hit) begin
          resp_data_d = bus.blk_data;
          if (hit_q != '1) hit_d = hit_q + BITS_COUNT'(1);
          state_d = S_RESPOND;
        end else begin
          if (miss_q != '1) miss_d = miss_q + BITS_COUNT'(1);
          state_d = S_MEM_REQ;
        end
      end
      S_MEM_REQ: begin
        if (bus.mem_req_ready) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (bus.mem_resp_valid) begin
          fill_data_d = bus.mem_resp_data;
          resp_data_d = bus.mem_resp_data;
          state_d     = S_FILL;
        end
      end
      S_FILL:    state_d = S_RESPOND;
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Every output is a register or a pure decode of the state register.
  assign bus.cpu_req_ready  = (state_q == S_IDLE);
  assign bus.cpu_resp_valid = (state_q == S_RESPOND);
  assign bus.blk_set        = (state_q == S_FILL);
  assign bus.mem_req_valid  = (state_q == S_MEM_REQ);
  assign bus.cpu_resp_data  = resp_data_q;
  assign bus.blk_fill_data  = fill_data_q;
  assign bus.blk_address    = addr_q;
  assign bus.mem_address    = addr_q;
  assign bus.hit_count      = hit_q;
  assign bus.miss_count     = miss_q;
endmodule
